// File: rtl/ram_wb_pkg.sv
// Shared widths and Wishbone cycle-type encodings for the ram_wb slave.
package ram_wb_pkg;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BL = DW / 8;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   function automatic logic [AW-1:0] adr_inc(input logic [AW-1:0] a);
      return a + AW'(1);
   endfunction

endpackage

// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// resettable read port (reset clears only the output register, not the array).
module ram_sp_be #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   adr,
   input  logic [DW-1:0]   din,
   input  logic [DW/8-1:0] wbe,
   input  logic            rd,
   output logic [DW-1:0]   dout
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      for (int b = 0; b < DW/8; b++) begin
         if (wbe[b]) mem[adr][8*b +: 8] <= din[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dout <= '0;
      else if (rd) dout <= mem[adr];
   end

endmodule

// File: rtl/ram_wb.sv
// Wishbone B3 classic/incrementing-burst slave in front of a byte-writable RAM.
// Reads prefetch the next burst word so every burst beat completes in one cycle.
module ram_wb
   import ram_wb_pkg::*;
#(
   parameter int AW = ram_wb_pkg::AW,
   parameter int DW = ram_wb_pkg::DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   adr_i,
   input  logic [DW-1:0]   dat_i,
   output logic [DW-1:0]   dat_o,
   input  logic            we_i,
   input  logic [DW/8-1:0] sel_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   output logic            ack_o,
   input  logic [2:0]      cti_i
);

   logic            req;
   logic            ack_next;
   logic            wr_beat;
   logic            rd_en;
   logic [AW-1:0]   rd_adr;
   logic [AW-1:0]   ram_adr;
   logic [DW/8-1:0] wbe;

   assign req      = cyc_i & stb_i;
   assign ack_next = req & (~ack_o | (cti_i == CTI_INCR));
   assign wr_beat  = req & ack_o & we_i;
   assign rd_en    = ack_next & ~we_i;

   // While acking, the word on dat_o belongs to the current beat; fetch the next.
   assign rd_adr   = ack_o ? adr_i + AW'(1) : adr_i;

   // Reads and writes never share an edge (we_i selects one), so one port suffices.
   assign ram_adr  = we_i ? adr_i : rd_adr;
   assign wbe      = {(DW/8){wr_beat}} & sel_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ack_o <= 1'b0;
      else      ack_o <= ack_next;
   end

   ram_sp_be #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .adr  (ram_adr),
      .din  (dat_i),
      .wbe  (wbe),
      .rd   (rd_en),
      .dout (dat_o)
   );

endmodule

// File: tb/tb_ram_wb.sv
// Randomized bench for ram_wb: a word-array memory model predicts ack and read
// data every cycle, plus directed transfers with literal expected values.
module tb_ram_wb;
   import ram_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  adr_i = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        we_i = 1'b0;
   logic [3:0]  sel_i = '0;
   logic        cyc_i = 1'b0;
   logic        stb_i = 1'b0;
   logic        ack_o;
   logic [2:0]  cti_i = CTI_CLASSIC;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] mem_m [1024];
   logic        m_ack = 1'b0;
   logic [31:0] m_dat = '0;
   logic [9:0]  m_ra;
   logic        m_req;
   logic        m_next;

   logic [31:0] wq [1024];
   logic [31:0] rq [1024];
   logic [31:0] keep [5];

   ram_wb dut (
      .clk   (clk),
      .rst   (rst),
      .adr_i (adr_i),
      .dat_i (dat_i),
      .dat_o (dat_o),
      .we_i  (we_i),
      .sel_i (sel_i),
      .cyc_i (cyc_i),
      .stb_i (stb_i),
      .ack_o (ack_o),
      .cti_i (cti_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a transfer is acked the cycle after it is requested; a burst
   // keeps acking while INCR is signalled; reads deliver the word of the beat
   // currently being acked, i.e. the next address once a burst is running.
   always begin
      @(posedge clk);
      if (!rst) begin
         m_ack = 1'b0;
         m_dat = '0;
      end else begin
         m_req  = cyc_i && stb_i;
         m_next = m_req && (!m_ack || cti_i == CTI_INCR);
         m_ra   = m_ack ? adr_i + 10'd1 : adr_i;
         if (m_next && !we_i) m_dat = mem_m[m_ra];
         if (m_req && m_ack && we_i) begin
            for (int b = 0; b < 4; b++)
               if (sel_i[b]) mem_m[adr_i][8*b +: 8] = dat_i[8*b +: 8];
         end
         m_ack = m_next;
      end
      #1;
      check("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
      check("dat_o", dat_o, m_dat);
   end

   // Master: presents beat i until a cycle where ack_o is high, then advances.
   task automatic xfer(input logic wr, input logic [9:0] start, input int n,
                       input logic [3:0] sel, input logic burst, input logic eob,
                       input logic keep_cyc, input logic [2:0] ccti, output int cycles);
      int  i;
      int  guard;
      logic a;
      i = 0;
      guard = 0;
      while (i < n && guard < n + 20) begin
         cyc_i = 1'b1;
         stb_i = 1'b1;
         we_i  = wr;
         sel_i = sel;
         adr_i = start + 10'(i);
         dat_i = wq[i];
         if (!burst)                cti_i = ccti;
         else if (i == n - 1 && eob) cti_i = CTI_EOB;
         else                        cti_i = CTI_INCR;
         a = ack_o;
         if (a && !wr) rq[i] = dat_o;
         @(negedge clk);
         guard++;
         if (a) i++;
      end
      cycles = guard;
      check("xfer_done", i, n);
      stb_i = 1'b0;
      if (!keep_cyc) cyc_i = 1'b0;
      cti_i = CTI_CLASSIC;
   endtask

   task automatic wr1(input logic [9:0] a, input logic [31:0] d, input logic [3:0] sel);
      int c;
      wq[0] = d;
      xfer(1'b1, a, 1, sel, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, c);
   endtask

   task automatic rd1(input logic [9:0] a, output logic [31:0] d);
      int c;
      xfer(1'b0, a, 1, 4'hF, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, c);
      d = rq[0];
   endtask

   initial begin
      int c;
      logic [31:0] d;
      logic [2:0] cl [6];
      cl[0] = 3'b000; cl[1] = 3'b001; cl[2] = 3'b011;
      cl[3] = 3'b100; cl[4] = 3'b101; cl[5] = 3'b111;

      // Reset held with a write request pending.
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hF;
      adr_i = 10'h000; dat_i = 32'h0BAD_F00D;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, ack_o}, 32'd0);
      check("rst_dat", dat_o, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("first_ack", {31'd0, ack_o}, 32'd1);
      @(negedge clk);
      check("classic_ack_drop", {31'd0, ack_o}, 32'd0);
      cyc_i = 1'b0; stb_i = 1'b0;
      @(negedge clk);

      // Fill the whole array with one long burst so every read is predictable.
      for (int i = 0; i < 1024; i++) wq[i] = $urandom;
      xfer(1'b1, 10'h000, 1024, 4'hF, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, c);
      check("preload_cycles", c, 1025);

      // Classic write then read.
      wq[0] = 32'hDEAD_BEEF;
      xfer(1'b1, 10'h005, 1, 4'hF, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, c);
      check("classic_wr_cycles", c, 2);
      xfer(1'b0, 10'h005, 1, 4'hF, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, c);
      check("classic_rd_cycles", c, 2);
      check("classic_rd_data", rq[0], 32'hDEAD_BEEF);

      // Byte lanes.
      wr1(10'h010, 32'h1122_3344, 4'hF);
      wr1(10'h010, 32'hAABB_CCDD, 4'b0101);
      rd1(10'h010, d);
      check("byte_lanes", d, 32'h11BB_33DD);
      wr1(10'h011, 32'h5555_6666, 4'hF);
      wr1(10'h011, 32'h0000_0000, 4'b0000);
      rd1(10'h011, d);
      check("sel_zero", d, 32'h5555_6666);

      // Burst read across the top-of-memory wrap.
      wr1(10'h3FE, 32'hAAAA_0001, 4'hF);
      wr1(10'h3FF, 32'hBBBB_0002, 4'hF);
      wr1(10'h000, 32'hCCCC_0003, 4'hF);
      xfer(1'b0, 10'h3FE, 3, 4'hF, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, c);
      check("burst_rd_cycles", c, 4);
      check("burst_rd_0", rq[0], 32'hAAAA_0001);
      check("burst_rd_1", rq[1], 32'hBBBB_0002);
      check("burst_rd_2", rq[2], 32'hCCCC_0003);
      check("burst_rd_end", {31'd0, ack_o}, 32'd0);

      // Four-beat burst write, neighbour must stay intact.
      wr1(10'h024, 32'h2424_2424, 4'hF);
      keep[0] = 32'h1000_0020; keep[1] = 32'h1000_0021;
      keep[2] = 32'h1000_0022; keep[3] = 32'h1000_0023;
      for (int i = 0; i < 4; i++) wq[i] = keep[i];
      xfer(1'b1, 10'h020, 4, 4'hF, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, c);
      check("burst_wr_cycles", c, 5);
      for (int i = 0; i < 4; i++) begin
         rd1(10'h020 + 10'(i), d);
         check("burst_wr_data", d, keep[i]);
      end
      rd1(10'h024, d);
      check("burst_wr_no_spill", d, 32'h2424_2424);

      // Abort by dropping stb_i after two beats of an open-ended burst.
      wr1(10'h032, 32'h3232_3232, 4'hF);
      wq[0] = 32'hFFFF_0030; wq[1] = 32'hFFFF_0031; wq[2] = 32'hFFFF_0032;
      xfer(1'b1, 10'h030, 2, 4'hF, 1'b1, 1'b0, 1'b1, CTI_CLASSIC, c);
      @(negedge clk);
      check("abort_ack", {31'd0, ack_o}, 32'd0);
      cyc_i = 1'b0;
      rd1(10'h031, d);
      check("abort_beat2", d, 32'hFFFF_0031);
      rd1(10'h032, d);
      check("abort_no_write", d, 32'h3232_3232);

      // Reset asserted in mid-burst acts without a clock edge.
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 10'h100; cti_i = CTI_INCR;
      @(negedge clk);
      @(negedge clk);
      check("burst_running", {31'd0, ack_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_ack", {31'd0, ack_o}, 32'd0);
      check("async_rst_dat", dat_o, 32'd0);
      cyc_i = 1'b0; stb_i = 1'b0; cti_i = CTI_CLASSIC;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Random mix of classic and burst traffic.
      repeat (150) begin
         logic wr;
         logic burst;
         int n;
         logic [9:0] start;
         wr    = 1'($urandom);
         burst = 1'($urandom);
         n     = burst ? 1 + int'($urandom_range(0, 5)) : 1;
         start = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom);
         for (int i = 0; i < n; i++) wq[i] = $urandom;
         xfer(wr, start, n, 4'($urandom), burst, 1'b1, 1'b0, cl[$urandom_range(0, 5)], c);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
